// File: rtl/bus_arbiter_rv32.sv
// Shares the rv32 system bus between the CPU and one external master, halting the CPU around each grant.
// Latency: grant HaltSettleCycles+1 cycles after request; ext read data 1 cycle after the beat. Ext backpressured
// by ext_ready_o (granted only), CPU by cpu_halt_o. BUS_ARB_STARVE_GUARD_EN enables the beat cap and CPU guard.
module bus_arbiter_rv32 #(
  parameter int address_width    = 32,
  parameter int data_width       = 32,
  parameter int HaltSettleCycles = 1,
  parameter int MaxExtBeats      = 16,
  parameter int CpuGuardCycles   = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [address_width-1:0] cpu_address_i,
  input  logic [data_width-1:0]    cpu_data_i,
  input  logic                     cpu_we_i,
  input  logic [3:0]               cpu_we_ram_i,
  output logic                     cpu_halt_o,
  output logic [address_width-1:0] bus_address_o,
  output logic [data_width-1:0]    bus_data_o,
  output logic                     bus_we_o,
  output logic [3:0]               bus_we_ram_o,
  output logic                     bus_hold_o,
  input  logic [data_width-1:0]    bus_rdata_i,
  input  logic                     ext_req_i,
  output logic                     ext_gnt_o,
  input  logic                     ext_valid_i,
  output logic                     ext_ready_o,
  input  logic                     ext_we_i,
  input  logic [3:0]               ext_be_i,
  input  logic [address_width-1:0] ext_address_i,
  input  logic [data_width-1:0]    ext_wdata_i,
  output logic [data_width-1:0]    ext_rdata_o,
  output logic                     ext_rvalid_o
);

`ifdef BUS_ARB_STARVE_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  localparam int SettleW = (HaltSettleCycles > 0) ? $clog2(HaltSettleCycles + 1) : 1;
  localparam int BeatW   = (MaxExtBeats > 0) ? $clog2(MaxExtBeats + 1) : 1;
  localparam int GuardW  = (CpuGuardCycles > 0) ? $clog2(CpuGuardCycles + 1) : 1;

  localparam logic [SettleW-1:0] SettleLast = SettleW'(HaltSettleCycles - 1);
  localparam logic [BeatW-1:0]   BeatLast   = BeatW'(MaxExtBeats - 1);
  localparam logic [GuardW-1:0]  GuardLoad  = GuardEn ? GuardW'(CpuGuardCycles) : '0;

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    HALT_WAIT = 2'd1,
    EXT_OWN   = 2'd2,
    RESTORE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SettleW-1:0] settle_cnt_q;
  logic [BeatW-1:0]   beat_cnt_q;
  logic [GuardW-1:0]  guard_cnt_q;
  logic               rd_pend_q;

  logic beat;
  logic beat_cap;
  logic guard_ok;
  logic cpu_writing;

  assign beat        = (state_q == EXT_OWN) && ext_valid_i;
  assign beat_cap    = GuardEn && (beat_cnt_q == BeatLast);
  // Counter expires at the end of this cycle, so the CPU keeps the bus for exactly CpuGuardCycles cycles.
  assign guard_ok    = (guard_cnt_q <= GuardW'(1));
  assign cpu_writing = cpu_we_i || (cpu_we_ram_i != 4'b0000);

  assign ext_rvalid_o = rd_pend_q;
  assign ext_rdata_o  = bus_rdata_i;

  always_comb begin
    state_d       = state_q;
    cpu_halt_o    = 1'b0;
    ext_gnt_o     = 1'b0;
    ext_ready_o   = 1'b0;
    bus_hold_o    = 1'b0;
    bus_address_o = cpu_address_i;
    bus_data_o    = cpu_data_i;
    bus_we_o      = cpu_we_i;
    bus_we_ram_o  = cpu_we_ram_i;
    case (state_q)
      CPU_OWN: begin
        if (ext_req_i && !cpu_writing && guard_ok) state_d = HALT_WAIT;
      end
      HALT_WAIT: begin
        // Hold keeps the CPU's pending read data in the mux while the pipeline drains.
        cpu_halt_o   = 1'b1;
        bus_hold_o   = 1'b1;
        bus_we_o     = 1'b0;
        bus_we_ram_o = 4'b0000;
        if (!ext_req_i)                      state_d = RESTORE;
        else if (settle_cnt_q == SettleLast) state_d = EXT_OWN;
      end
      EXT_OWN: begin
        cpu_halt_o    = 1'b1;
        ext_gnt_o     = 1'b1;
        ext_ready_o   = 1'b1;
        bus_address_o = ext_address_i;
        bus_data_o    = ext_wdata_i;
        bus_we_o      = beat && ext_we_i;
        bus_we_ram_o  = (beat && ext_we_i) ? ext_be_i : 4'b0000;
        if (!ext_req_i || (beat && beat_cap)) state_d = RESTORE;
      end
      RESTORE: begin
        cpu_halt_o   = 1'b1;
        bus_we_o     = 1'b0;
        bus_we_ram_o = 4'b0000;
        state_d      = CPU_OWN;
      end
      default: state_d = CPU_OWN;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= CPU_OWN;
      settle_cnt_q <= '0;
      beat_cnt_q   <= '0;
      guard_cnt_q  <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= beat && !ext_we_i;

      if (state_q == HALT_WAIT) settle_cnt_q <= settle_cnt_q + 1'b1;
      else                      settle_cnt_q <= '0;

      if (state_q != EXT_OWN) beat_cnt_q <= '0;
      else if (beat)          beat_cnt_q <= beat_cnt_q + 1'b1;

      if (state_q == RESTORE)                             guard_cnt_q <= GuardLoad;
      else if (state_q == CPU_OWN && guard_cnt_q != '0)   guard_cnt_q <= guard_cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rv32.sv
// Bench for bus_arbiter_rv32: RAM/read-mux environment, protocol monitor with a reference memory,
// directed scenarios plus randomized external-master sessions.
module tb_bus_arbiter_rv32;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] cpu_address_i, cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_we_ram_i;
  logic        cpu_halt_o;
  logic [31:0] bus_address_o, bus_data_o;
  logic        bus_we_o;
  logic [3:0]  bus_we_ram_o;
  logic        bus_hold_o;
  logic [31:0] bus_rdata_i;
  logic        ext_req_i, ext_gnt_o, ext_valid_i, ext_ready_o, ext_we_i;
  logic [3:0]  ext_be_i;
  logic [31:0] ext_address_i, ext_wdata_i, ext_rdata_o;
  logic        ext_rvalid_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bus_arbiter_rv32 dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cpu_address_i(cpu_address_i), .cpu_data_i(cpu_data_i), .cpu_we_i(cpu_we_i),
    .cpu_we_ram_i(cpu_we_ram_i), .cpu_halt_o(cpu_halt_o),
    .bus_address_o(bus_address_o), .bus_data_o(bus_data_o), .bus_we_o(bus_we_o),
    .bus_we_ram_o(bus_we_ram_o), .bus_hold_o(bus_hold_o), .bus_rdata_i(bus_rdata_i),
    .ext_req_i(ext_req_i), .ext_gnt_o(ext_gnt_o), .ext_valid_i(ext_valid_i),
    .ext_ready_o(ext_ready_o), .ext_we_i(ext_we_i), .ext_be_i(ext_be_i),
    .ext_address_i(ext_address_i), .ext_wdata_i(ext_wdata_i),
    .ext_rdata_o(ext_rdata_o), .ext_rvalid_o(ext_rvalid_o)
  );

  // RAM, peripheral strobe counter and read-mux data register around the arbiter
  logic [31:0] mem [0:1023];
  logic [31:0] data_reg;
  int          periph_cnt = 0;
  assign bus_rdata_i = data_reg;

  always @(posedge clk_i) begin
    for (int b = 0; b < 4; b++)
      if (bus_we_ram_o[b]) mem[bus_address_o[11:2]][8*b +: 8] <= bus_data_o[8*b +: 8];
    if (!bus_hold_o) data_reg <= mem[bus_address_o[11:2]];
    if (bus_we_o) periph_cnt <= periph_cnt + 1;
  end

  // Reference memory: changed only by un-halted CPU writes and accepted ext write beats
  logic [31:0] ref_mem [0:1023];
  bit          exp_rv;
  logic [31:0] exp_rd;
  logic [31:0] bdat [4] = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    step();
    cpu_address_i = a;
    cpu_data_i    = d;
    cpu_we_ram_i  = 4'hF;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    @(negedge clk_i);
    while (!ext_gnt_o && n < 30) begin
      step();
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_gnt"}, 32'(ext_gnt_o), 32'd1);
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    @(negedge clk_i);
    while (cpu_halt_o && n < 30) begin
      step();
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_release"}, 32'(cpu_halt_o), 32'd0);
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h400 + 32'(4 * $urandom_range(0, 15));
  endfunction

  // Protocol monitor, sampled mid-cycle
  initial begin
    bit beat;
    exp_rv = 1'b0;
    exp_rd = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        exp_rv = 1'b0;
      end else begin
        beat = ext_valid_i && ext_ready_o;
        chk("rvalid", 32'(ext_rvalid_o), 32'(exp_rv));
        if (exp_rv) chk("rdata", ext_rdata_o, exp_rd);
        if (!ext_gnt_o) chk("ready_no_gnt", 32'(ext_ready_o), 32'd0);
        if (ext_gnt_o) begin
          chk("gnt_halt", 32'(cpu_halt_o), 32'd1);
          chk("ext_addr", bus_address_o, ext_address_i);
          chk("ext_we_ram", 32'(bus_we_ram_o), 32'((beat && ext_we_i) ? ext_be_i : 4'h0));
          chk("ext_we", 32'(bus_we_o), 32'(beat && ext_we_i));
          if (beat && ext_we_i) chk("ext_wdata", bus_data_o, ext_wdata_i);
        end else if (!cpu_halt_o) begin
          chk("pt_addr", bus_address_o, cpu_address_i);
          chk("pt_we", 32'(bus_we_o), 32'(cpu_we_i));
          chk("pt_we_ram", 32'(bus_we_ram_o), 32'(cpu_we_ram_i));
          chk("pt_hold", 32'(bus_hold_o), 32'd0);
        end else begin
          chk("halt_no_write", 32'({bus_we_o, bus_we_ram_o}), 32'd0);
        end
        exp_rv = beat && !ext_we_i;
        if (exp_rv) exp_rd = ref_mem[ext_address_i[11:2]];
        if (!cpu_halt_o) ref_write(cpu_address_i, cpu_data_i, cpu_we_ram_i);
        if (beat && ext_we_i) ref_write(ext_address_i, ext_wdata_i, ext_be_i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, beats, low, nb, done, cyc;
    bit dropped;
    logic [31:0] old;
    reset_n_i     = 1'b0;
    cpu_address_i = 32'h400;
    cpu_data_i    = '0;
    cpu_we_i      = 1'b0;
    cpu_we_ram_i  = 4'h0;
    ext_req_i     = 1'b0;
    ext_valid_i   = 1'b0;
    ext_we_i      = 1'b0;
    ext_be_i      = 4'h0;
    ext_address_i = '0;
    ext_wdata_i   = '0;

    #12;
    chk("rst_halt", 32'(cpu_halt_o), 32'd0);
    chk("rst_gnt", 32'(ext_gnt_o), 32'd0);
    chk("rst_ready", 32'(ext_ready_o), 32'd0);
    chk("rst_rvalid", 32'(ext_rvalid_o), 32'd0);
    chk("rst_addr", bus_address_o, 32'h400);
    step();
    reset_n_i = 1'b1;

    cpu_wr(32'h100, 32'hDEADBEEF);
    cpu_wr(32'h300, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) cpu_wr(32'h200 + 32'(4 * i), 32'hA0B0C0D0 + 32'(i));
    for (int i = 0; i < 16; i++) cpu_wr(32'h400 + 32'(4 * i), $urandom);
    step();
    cpu_we_ram_i  = 4'h0;
    cpu_address_i = 32'h400;
    idle(2);

    // Single read
    step(); ext_req_i = 1'b1;
    @(negedge clk_i);
    chk("t0_halt", 32'(cpu_halt_o), 32'd0);
    step();
    @(negedge clk_i);
    chk("t1_halt", 32'(cpu_halt_o), 32'd1);
    chk("t1_gnt", 32'(ext_gnt_o), 32'd0);
    chk("t1_hold", 32'(bus_hold_o), 32'd1);
    step(); ext_valid_i = 1'b1; ext_we_i = 1'b0; ext_address_i = 32'h100;
    @(negedge clk_i);
    chk("t2_gnt", 32'(ext_gnt_o), 32'd1);
    chk("t2_ready", 32'(ext_ready_o), 32'd1);
    step(); ext_valid_i = 1'b0; ext_req_i = 1'b0;
    @(negedge clk_i);
    chk("t3_rvalid", 32'(ext_rvalid_o), 32'd1);
    chk("t3_rdata", ext_rdata_o, 32'hDEADBEEF);
    step();
    @(negedge clk_i);
    chk("t4_halt", 32'(cpu_halt_o), 32'd1);
    chk("t4_gnt", 32'(ext_gnt_o), 32'd0);
    chk("t4_hold", 32'(bus_hold_o), 32'd0);
    chk("t4_addr", bus_address_o, 32'h400);
    step();
    @(negedge clk_i);
    chk("t5_halt", 32'(cpu_halt_o), 32'd0);

    // Write burst with byte enables 0011 and one idle gap
    idle(6);
    step(); ext_req_i = 1'b1;
    wait_gnt("burst");
    for (int i = 0; i < 4; i++) begin
      step();
      ext_valid_i = 1'b1; ext_we_i = 1'b1; ext_be_i = 4'b0011;
      ext_address_i = 32'h200 + 32'(4 * i); ext_wdata_i = bdat[i];
      @(negedge clk_i);
      chk("burst_we_ram", 32'(bus_we_ram_o), 32'h3);
      if (i == 1) begin
        step(); ext_valid_i = 1'b0;
        @(negedge clk_i);
        chk("burst_gap_we_ram", 32'(bus_we_ram_o), 32'h0);
      end
    end
    step(); ext_valid_i = 1'b0; ext_req_i = 1'b0;
    wait_release("burst");
    for (int i = 0; i < 4; i++) begin
      old = 32'hA0B0C0D0 + 32'(i);
      chk("burst_mem", mem[32 * 4 + i], {old[31:16], bdat[i][15:0]});
    end

    // CPU peripheral write collides with the request
    idle(6);
    base = periph_cnt;
    step(); cpu_address_i = 32'hF000_0010; cpu_data_i = 32'h5A5A_0001; cpu_we_i = 1'b1; ext_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge clk_i);
      chk("coll_no_halt", 32'(cpu_halt_o), 32'd0);
    end
    step(); cpu_we_i = 1'b0; cpu_address_i = 32'h300;
    @(negedge clk_i);
    chk("coll_leave_cycle", 32'(cpu_halt_o), 32'd0);
    step(); ext_req_i = 1'b0;
    @(negedge clk_i);
    chk("coll_halt", 32'(cpu_halt_o), 32'd1);
    chk("coll_hw_gnt", 32'(ext_gnt_o), 32'd0);
    step();
    @(negedge clk_i);
    chk("coll_restore_halt", 32'(cpu_halt_o), 32'd1);
    chk("coll_restore_addr", bus_address_o, 32'h300);
    step();
    @(negedge clk_i);
    chk("coll_released", 32'(cpu_halt_o), 32'd0);
    chk("coll_strobes", 32'(periph_cnt - base), 32'd3);
    chk("coll_data_reg", data_reg, 32'hCAFEF00D);

    // CPU pending read on 0x300 survives an ext read of 0x100
    idle(6);
    step(); ext_req_i = 1'b1;
    wait_gnt("rr");
    step(); ext_valid_i = 1'b1; ext_we_i = 1'b0; ext_address_i = 32'h100;
    @(negedge clk_i);
    step(); ext_valid_i = 1'b0; ext_req_i = 1'b0;
    @(negedge clk_i);
    chk("rr_ext_data", data_reg, 32'hDEADBEEF);
    step();
    wait_release("rr");
    chk("rr_cpu_data", data_reg, 32'hCAFEF00D);

    // Long request with a beat every cycle
    idle(6);
    step(); ext_req_i = 1'b1; ext_valid_i = 1'b1; ext_we_i = 1'b0; ext_address_i = rnd_addr();
    wait_gnt("guard");
    beats = 0; low = 0; dropped = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        step(); ext_address_i = rnd_addr();
        @(negedge clk_i);
      end
      if (!dropped) begin
        if (!ext_gnt_o) dropped = 1'b1;
        else if (ext_valid_i && ext_ready_o) beats++;
      end
      if (dropped && !cpu_halt_o) low++;
    end
`ifdef BUS_ARB_STARVE_GUARD_EN
    chk("guard_beats", 32'(beats), 32'd16);
    chk("guard_dropped", 32'(dropped), 32'd1);
    chk("guard_low_cycles", 32'(low), 32'd4);
`else
    chk("guard_beats", 32'(beats), 32'd40);
    chk("guard_dropped", 32'(dropped), 32'd0);
`endif
    step(); ext_valid_i = 1'b0; ext_req_i = 1'b0;
    wait_release("guard");

    // Reset while granted with a read in flight
    idle(6);
    step(); ext_req_i = 1'b1;
    wait_gnt("rst_mid");
    step(); ext_valid_i = 1'b1; ext_we_i = 1'b0; ext_address_i = 32'h404;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    chk("rst_mid_pre_rvalid", 32'(ext_rvalid_o), 32'd1);
    reset_n_i = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(ext_rvalid_o), 32'd0);
    chk("rst_mid_gnt", 32'(ext_gnt_o), 32'd0);
    chk("rst_mid_ready", 32'(ext_ready_o), 32'd0);
    chk("rst_mid_halt", 32'(cpu_halt_o), 32'd0);
    chk("rst_mid_addr", bus_address_o, cpu_address_i);
    ext_req_i = 1'b0; ext_valid_i = 1'b0;
    step();
    reset_n_i = 1'b1;

    // Randomized sessions
    for (int s = 0; s < 20; s++) begin
      idle($urandom_range(0, 6));
      step();
      cpu_address_i = rnd_addr();
      ext_req_i     = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        cpu_we_ram_i = 4'($urandom_range(1, 15));
        cpu_data_i   = $urandom;
      end
      ext_valid_i   = 1'($urandom_range(0, 1));
      ext_we_i      = 1'b1;
      ext_be_i      = 4'hF;
      ext_address_i = rnd_addr();
      ext_wdata_i   = $urandom;
      @(negedge clk_i);
      step(); cpu_we_ram_i = 4'h0;
      wait_gnt("sess");
      nb = $urandom_range(1, 8);
      done = (ext_valid_i && ext_ready_o) ? 1 : 0;
      cyc = 0;
      while (done < nb && cyc < 100) begin
        step();
        ext_valid_i   = ($urandom_range(0, 3) != 0);
        ext_we_i      = 1'($urandom_range(0, 1));
        ext_be_i      = 4'($urandom_range(1, 15));
        ext_address_i = rnd_addr();
        ext_wdata_i   = $urandom;
        @(negedge clk_i);
        if (ext_valid_i && ext_ready_o) done++;
        cyc++;
      end
      chk("sess_beats", 32'(done), 32'(nb));
      step(); ext_valid_i = 1'b0; ext_req_i = 1'b0;
      wait_release("sess");
      chk("sess_cpu_restore", data_reg, ref_mem[cpu_address_i[11:2]]);
    end

    idle(2);
    chk("mem_100", mem[64], ref_mem[64]);
    chk("mem_300", mem[192], ref_mem[192]);
    for (int i = 0; i < 4; i++) chk("mem_200", mem[128 + i], ref_mem[128 + i]);
    for (int i = 0; i < 16; i++) chk("mem_400", mem[256 + i], ref_mem[256 + i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
